// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-cycle memory between an instruction
// read port and a data read/write port. IDLE -> ACC -> DONE per transaction.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic        i_err,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] addr,
   output logic [31:0] wd,
   input  logic [31:0] rd,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;   // 1 = data port owns the transaction
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic        last_q, last_d;     // 1 = data port was served last
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wd_q, wd_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;

   logic        pick_d;
   logic [31:0] win_addr;
   logic        win_we;
   logic [31:0] win_wdata;
   logic        win_bad;
   logic [31:0] cap_data;

   // Data wins only when alone or when the instruction port was served last.
   assign pick_d    = d_req && (!i_req || !last_q);
   assign win_addr  = pick_d ? d_addr : i_addr;
   assign win_we    = pick_d && d_we;
   assign win_wdata = win_we ? d_wdata : 32'd0;
   assign win_bad   = (win_addr[1:0] != 2'b00) || (win_addr > 32'd1020);
   assign cap_data  = we_q ? 32'd0 : rd;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      err_d       = err_q;
      last_d      = last_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      addr_d      = 32'd0;
      wd_d        = 32'd0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               owner_d = pick_d;
               we_d    = win_we;
               err_d   = win_bad;
               last_d  = pick_d;
               if (win_bad) begin
                  // Error completions skip memory and report zero data.
                  state_d = DONE;
                  if (pick_d) d_rdata_d = 32'd0;
                  else        i_rdata_d = 32'd0;
               end else begin
                  state_d     = ACC;
                  mem_read_d  = ~win_we;
                  mem_write_d = win_we;
                  addr_d      = win_addr;
                  wd_d        = win_wdata;
               end
            end
         end
         ACC: begin
            state_d = DONE;
            if (owner_q) d_rdata_d = cap_data;
            else         i_rdata_d = cap_data;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         last_q      <= 1'b1;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         addr_q      <= 32'd0;
         wd_q        <= 32'd0;
         i_rdata_q   <= 32'd0;
         d_rdata_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         err_q       <= err_d;
         last_q      <= last_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         addr_q      <= addr_d;
         wd_q        <= wd_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign i_ack    = (state_q == DONE) && !owner_q;
   assign d_ack    = (state_q == DONE) && owner_q;
   assign i_err    = i_ack && err_q;
   assign d_err    = d_ack && err_q;
   assign i_rdata  = i_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign MemRead  = mem_read_q;
   assign MemWrite = mem_write_q;
   assign addr     = addr_q;
   assign wd       = wd_q;
   assign busy     = (state_q != IDLE);

endmodule
